mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the CPU's single 16-bit memory port between two requesters:
  - the instruction-fetch path, which is read-only;
  - the load/store data path, which reads and writes.
- Issues at most one access per cycle.
- Uses fixed-priority arbitration with an anti-starvation counter.
- Tracks in-flight reads through a latency pipeline and returns each read response to the requester that issued it.
- Sits between the cpu core and the memory; it replaces the core's direct drive of o_mem_addr, o_mem_rd and o_mem_wr.

Parameters:
- AW, 16: address width.
- DW, 16: data width.
- RD_LAT, 1: cycles from a read issue to valid i_mem_rddata. Must be 1 to 4.
- MAX_STARVE, 4: consecutive denied fetch cycles that force a fetch grant. Must be 1 to 15.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous active-low reset.
- if_req, input, 1: fetch request.
- if_addr, input, AW: fetch address.
- if_gnt, output, 1: fetch request issued this cycle.
- if_rvalid, output, 1: fetch read data valid.
- if_rdata, output, DW: fetch read data.
- d_req, input, 1: data request.
- d_we, input, 1: 1 = write, 0 = read.
- d_addr, input, AW: data address.
- d_wdata, input, DW: write data.
- d_gnt, output, 1: data request issued this cycle.
- d_rvalid, output, 1: data read data valid.
- d_rdata, output, DW: data read data.
- o_mem_addr, output, AW: memory address.
- o_mem_rd, output, 1: memory read strobe.
- o_mem_wr, output, 1: memory write strobe.
- o_mem_wrdata, output, DW: memory write data.
- i_mem_rddata, input, DW: memory read data, valid RD_LAT cycles after the o_mem_rd cycle.

Behaviour:

Handshake:
- A requester holds req and all its request fields stable until it sees gnt=1 at a rising edge.
- The request is consumed at that edge.
- A requester may drop req only after it has been granted.

Arbitration (combinational, same cycle):
- Only d_req: data granted.
- Only if_req: fetch granted.
- Both: data granted, unless starve_cnt equals MAX_STARVE; then fetch is granted.
- Neither: no grant.
- if_gnt and d_gnt are never both 1.

Memory drive (combinational from the granted requester):
- Fetch grant: o_mem_addr=if_addr, o_mem_rd=1, o_mem_wr=0.
- Data read: o_mem_addr=d_addr, o_mem_rd=1, o_mem_wr=0.
- Data write: o_mem_addr=d_addr, o_mem_wr=1, o_mem_rd=0, o_mem_wrdata=d_wdata.
- No grant: all memory outputs are 0.

starve_cnt (4-bit register):
- Increments, saturating at MAX_STARVE, on each edge where if_req=1 and if_gnt=0.
- Clears on an edge where if_gnt=1 or if_req=0.

Read-return pipeline (RD_LAT stages):
- Each stage holds a valid bit and an owner bit (0 = fetch, 1 = data).
- A read grant enters stage 0 at the clock edge.
- Writes and idle cycles enter as invalid.
- When the last stage is valid, the owner's rvalid is 1 and its rdata = i_mem_rddata, passed through combinationally.
- The other rvalid is 0.
- When a requester's rvalid=0, its rdata reads 0.
- Reads are fully pipelined: one new read per cycle, no outstanding limit, responses in issue order.
- Example, RD_LAT=1: a grant in cycle N gives rvalid in cycle N+1.
- Responses cannot be stalled; requesters must accept rvalid unconditionally.

Reset (reset=0, asynchronous):
- All pipeline valid bits clear to 0.
- starve_cnt clears to 0.
- All outputs are 0 while reset is low: no grant, no memory strobes, rvalid=0, rdata=0.
- Reads in flight when reset asserts are dropped; no rvalid is produced for them after reset releases.
- The first grant is possible in the first cycle after reset releases.

Boundary conditions:
- Back-to-back data requests with if_req held: fetch is forced on the (MAX_STARVE+1)th contended cycle. Data is then granted the cycle after.
- A data write followed immediately by a read of the same address is issued in order. Data hazards belong to memory.
- A write grant never produces rvalid.

Test Plan:
1. Fetch only, RD_LAT=1: if_req=1, if_addr=0x0010, memory returns 0xA5A5. Required: if_gnt=1 in cycle N, o_mem_rd=1, o_mem_addr=0x0010; if_rvalid=1 with if_rdata=0xA5A5 in N+1; d_rvalid=0 throughout.
2. Contention, MAX_STARVE=4: if_req and d_req held high, data requests reads at 0x0100, 0x0102, 0x0104 and so on. Required: d_gnt in cycles 0 to 3; if_gnt in cycle 4, with starve_cnt=4 at the start of cycle 4; d_gnt in cycle 5; starve_cnt=0 at the start of cycle 5.
3. Write: d_req=1, d_we=1, d_addr=0x0200, d_wdata=0x1234. Required: o_mem_wr=1, o_mem_rd=0, o_mem_wrdata=0x1234 in the grant cycle; no d_rvalid or if_rvalid in the following RD_LAT+2 cycles.
4. RD_LAT=3, interleaved reads issued in cycles 0 to 3 in the order fetch, data, data, fetch. Required: rvalid in cycles 3 to 6 with owners fetch, data, data, fetch; each rdata matches i_mem_rddata in that cycle.
5. Reset mid-flight, RD_LAT=2: data read granted in cycle 0, reset pulsed low during cycle 1. Required: no d_rvalid in cycle 2 or later; after reset releases, a new fetch to 0x0000 completes normally with starve_cnt starting at 0.
6. Idle: if_req=0 and d_req=0 for 5 cycles. Required: o_mem_rd=0, o_mem_wr=0, o_mem_addr=0 and o_mem_wrdata=0 every cycle; no gnt; no rvalid.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the instruction-fetch
// path (read-only) and the load/store data path. Data normally wins, but a
// fetch that has been denied MAX_STARVE times in a row is forced through.
// Read responses are routed back through an RD_LAT-deep owner pipeline.
// MAX_STARVE must be 1..15 (4-bit counter); RD_LAT must be 1..4.
module mem_port_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int RD_LAT     = 1,
  parameter int MAX_STARVE = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_rd,
  output logic          o_mem_wr,
  output logic [DW-1:0] o_mem_wrdata,
  input  logic [DW-1:0] i_mem_rddata
);

  localparam logic [3:0] STARVE_LIMIT = 4'(MAX_STARVE);

  logic [3:0] starve_cnt_reg;
  logic [3:0] starve_cnt_next;
  logic       fetch_win;
  logic       last_valid;
  logic       last_owner;

  // Data has priority unless fetch has reached its starvation limit;
  // grants are held off entirely while reset is asserted.
  always_comb begin
    fetch_win = if_req && (!d_req || (starve_cnt_reg == STARVE_LIMIT));
    if_gnt    = reset && fetch_win;
    d_gnt     = reset && d_req && !fetch_win;
  end

  // Memory port is driven only by the granted requester, otherwise all zero.
  always_comb begin
    o_mem_addr   = '0;
    o_mem_rd     = 1'b0;
    o_mem_wr     = 1'b0;
    o_mem_wrdata = '0;
    if (if_gnt) begin
      o_mem_addr = if_addr;
      o_mem_rd   = 1'b1;
    end else if (d_gnt) begin
      o_mem_addr = d_addr;
      o_mem_rd   = !d_we;
      o_mem_wr   = d_we;
      if (d_we) begin
        o_mem_wrdata = d_wdata;
      end
    end
  end

  // Count consecutive denied fetch cycles, saturating at the limit.
  always_comb begin
    starve_cnt_next = 4'd0;
    if (if_req && !if_gnt) begin
      starve_cnt_next = (starve_cnt_reg == STARVE_LIMIT) ? STARVE_LIMIT
                                                         : starve_cnt_reg + 4'd1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_reg <= 4'd0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  // Read-return pipeline: each stage carries (valid, owner); owner 1 = data.
  genvar gi;
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_stage
      logic stage_valid;
      logic stage_owner;
      logic in_valid;
      logic in_owner;
      if (gi == 0) begin : g_in
        assign in_valid = o_mem_rd;
        assign in_owner = d_gnt;
      end else begin : g_in
        assign in_valid = g_stage[gi-1].stage_valid;
        assign in_owner = g_stage[gi-1].stage_owner;
      end
      // Advance one stage per clock; in-flight reads are dropped on reset.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          stage_valid <= 1'b0;
          stage_owner <= 1'b0;
        end else begin
          stage_valid <= in_valid;
          stage_owner <= in_owner;
        end
      end
    end
  endgenerate

  assign last_valid = g_stage[RD_LAT-1].stage_valid;
  assign last_owner = g_stage[RD_LAT-1].stage_owner;

  // Route the returning memory data to the owner of the oldest read.
  always_comb begin
    if_rvalid = reset && last_valid && !last_owner;
    d_rvalid  = reset && last_valid && last_owner;
    if_rdata  = if_rvalid ? i_mem_rddata : '0;
    d_rdata   = d_rvalid ? i_mem_rddata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level reference model (grant rule, starvation
// count and a queue of expected read responses with their due cycles).
module tb_mem_port_arbiter;

  localparam int RD_LAT     = 3;
  localparam int MAX_STARVE = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we;
  logic [15:0] if_addr, d_addr, d_wdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid;
  logic [15:0] if_rdata, d_rdata;
  logic [15:0] o_mem_addr, o_mem_wrdata, i_mem_rddata;
  logic        o_mem_rd, o_mem_wr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(16), .DW(16), .RD_LAT(RD_LAT), .MAX_STARVE(MAX_STARVE)) dut (
    .clk(clk), .reset(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .o_mem_addr(o_mem_addr), .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr),
    .o_mem_wrdata(o_mem_wrdata), .i_mem_rddata(i_mem_rddata)
  );

  // ---------------- memory model (4K words, aliased on addr[11:0]) ----------
  logic [15:0] mem [0:4095];
  logic [15:0] rd_pipe [RD_LAT];

  function automatic logic [15:0] mem_peek(input logic [15:0] a);
    return mem[a[11:0]];
  endfunction

  // Initial contents are addr ^ 5A3C, except 0x0010 holds A5A5.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4096; i++) begin
        mem[i] <= (i == 16) ? 16'hA5A5 : (16'(i) ^ 16'h5A3C);
      end
      for (int i = 0; i < RD_LAT; i++) rd_pipe[i] <= 16'h0;
    end else begin
      if (o_mem_wr) mem[o_mem_addr[11:0]] <= o_mem_wrdata;
      rd_pipe[0] <= o_mem_rd ? mem_peek(o_mem_addr) : 16'($urandom);
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end
  assign i_mem_rddata = rd_pipe[RD_LAT-1];

  // ---------------- reference model -----------------------------------------
  typedef struct {
    int          due;
    logic        owner;
    logic [15:0] data;
  } resp_t;

  resp_t       resp_q[$];
  int          starve_m;
  int          cyc_m;
  logic        exp_if_gnt, exp_d_gnt;
  logic        exp_rv_if, exp_rv_d;
  logic [15:0] exp_rdata;

  assign exp_if_gnt = rst_n && if_req && (!d_req || starve_m == MAX_STARVE);
  assign exp_d_gnt  = rst_n && d_req && !exp_if_gnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_q.delete();
      starve_m <= 0;
      cyc_m    <= 0;
    end else begin
      if (exp_if_gnt)
        resp_q.push_back('{cyc_m + RD_LAT, 1'b0, mem_peek(if_addr)});
      else if (exp_d_gnt && !d_we)
        resp_q.push_back('{cyc_m + RD_LAT, 1'b1, mem_peek(d_addr)});
      if (resp_q.size() > 0 && resp_q[0].due == cyc_m) void'(resp_q.pop_front());
      starve_m <= (if_req && !exp_if_gnt) ? ((starve_m < MAX_STARVE) ? starve_m + 1 : MAX_STARVE) : 0;
      cyc_m    <= cyc_m + 1;
    end
  end

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_rv_if <= 1'b0; exp_rv_d <= 1'b0; exp_rdata <= 16'h0;
    end else if (resp_q.size() > 0 && resp_q[0].due == cyc_m) begin
      exp_rv_if <= !resp_q[0].owner;
      exp_rv_d  <= resp_q[0].owner;
      exp_rdata <= resp_q[0].data;
    end else begin
      exp_rv_if <= 1'b0; exp_rv_d <= 1'b0; exp_rdata <= 16'h0;
    end
  end

  // Drive point (just after the rising edge) and sample point (after falling edge).
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;
  endtask

  // ---------------- scenarios -----------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    if_req = 1'b1; if_addr = 16'h1234; d_req = 1'b1; d_we = 1'b1;
    d_addr = 16'h4321; d_wdata = 16'hFFFF;
    for (int k = 0; k < 3; k++) begin
      mid();
      total++;
      if ({if_gnt, d_gnt, o_mem_rd, o_mem_wr} !== 4'b0) begin
        bad++; $display("FAIL reset_strobes: got %b want 0000", {if_gnt, d_gnt, o_mem_rd, o_mem_wr});
      end
      total++;
      if ({o_mem_addr, o_mem_wrdata} !== 32'h0) begin
        bad++; $display("FAIL reset_mem_bus: got %h want 0", {o_mem_addr, o_mem_wrdata});
      end
      total++;
      if ({if_rvalid, d_rvalid, if_rdata, d_rdata} !== 34'h0) begin
        bad++; $display("FAIL reset_resp: got %h want 0", {if_rvalid, d_rvalid, if_rdata, d_rdata});
      end
      total++;
      if (dut.starve_cnt_reg !== 4'd0) begin
        bad++; $display("FAIL reset_starve: got %0d want 0", dut.starve_cnt_reg);
      end
    end
    step();
    rst_n = 1'b1;
    idle_inputs();
    $display("test_reset: done");
  endtask

  task automatic test_fetch_only();
    for (int k = 0; k <= RD_LAT + 1; k++) begin
      step();
      idle_inputs();
      if (k == 0) begin if_req = 1'b1; if_addr = 16'h0010; end
      mid();
      if (k == 0) begin
        total++;
        if (if_gnt !== 1'b1 || o_mem_rd !== 1'b1 || o_mem_addr !== 16'h0010) begin
          bad++; $display("FAIL fetch_issue: got gnt=%b rd=%b addr=%h want 1 1 0010", if_gnt, o_mem_rd, o_mem_addr);
        end
      end
      total++;
      if (if_rvalid !== (k == RD_LAT) || d_rvalid !== 1'b0) begin
        bad++; $display("FAIL fetch_rvalid k=%0d: got if=%b d=%b want if=%b d=0", k, if_rvalid, d_rvalid, k == RD_LAT);
      end
      if (k == RD_LAT) begin
        total++;
        if (if_rdata !== 16'hA5A5) begin
          bad++; $display("FAIL fetch_rdata: got %h want a5a5", if_rdata);
        end
      end
    end
    $display("test_fetch_only: done");
  endtask

  task automatic test_contention();
    logic [15:0] next_d = 16'h0100;
    for (int k = 0; k <= MAX_STARVE + 1; k++) begin
      step();
      if_req = 1'b1; if_addr = 16'h0300;
      d_req = 1'b1; d_we = 1'b0; d_addr = next_d;
      mid();
      total++;
      if (if_gnt !== (k == MAX_STARVE) || d_gnt !== (k != MAX_STARVE)) begin
        bad++; $display("FAIL contention_gnt k=%0d: got if=%b d=%b want if=%b", k, if_gnt, d_gnt, k == MAX_STARVE);
      end
      if (k >= MAX_STARVE) begin
        total++;
        if (dut.starve_cnt_reg !== ((k == MAX_STARVE) ? 4'(MAX_STARVE) : 4'd0)) begin
          bad++; $display("FAIL contention_starve k=%0d: got %0d", k, dut.starve_cnt_reg);
        end
      end
      if (d_gnt) next_d = next_d + 16'h2;
    end
    step(); idle_inputs();
    for (int k = 0; k < RD_LAT; k++) step();
    $display("test_contention: done");
  endtask

  task automatic test_write();
    for (int k = 0; k <= RD_LAT + 2; k++) begin
      step();
      idle_inputs();
      if (k == 0) begin d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234; end
      mid();
      if (k == 0) begin
        total++;
        if (d_gnt !== 1'b1 || o_mem_wr !== 1'b1 || o_mem_rd !== 1'b0 ||
            o_mem_wrdata !== 16'h1234 || o_mem_addr !== 16'h0200) begin
          bad++; $display("FAIL write_issue: got gnt=%b wr=%b rd=%b addr=%h wd=%h", d_gnt, o_mem_wr, o_mem_rd, o_mem_addr, o_mem_wrdata);
        end
      end
      total++;
      if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin
        bad++; $display("FAIL write_no_rvalid k=%0d: got d=%b if=%b want 0 0", k, d_rvalid, if_rvalid);
      end
    end
    // Write immediately followed by a read of the same address.
    for (int k = 0; k <= RD_LAT + 1; k++) begin
      step();
      idle_inputs();
      if (k == 0) begin d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0202; d_wdata = 16'hBEEF; end
      if (k == 1) begin d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0202; end
      mid();
      if (k == 1) begin
        total++;
        if (o_mem_rd !== 1'b1 || o_mem_addr !== 16'h0202) begin
          bad++; $display("FAIL wr_rd_issue: got rd=%b addr=%h want 1 0202", o_mem_rd, o_mem_addr);
        end
      end
      if (k == RD_LAT + 1) begin
        total++;
        if (d_rvalid !== 1'b1 || d_rdata !== 16'hBEEF) begin
          bad++; $display("FAIL wr_rd_data: got v=%b data=%h want 1 beef", d_rvalid, d_rdata);
        end
      end
    end
    $display("test_write: done");
  endtask

  task automatic test_interleave();
    logic [3:0]  kind = 4'b0110;   // bit c set: data read in cycle c, else fetch
    logic [15:0] a;
    for (int c = 0; c <= RD_LAT + 3; c++) begin
      step();
      idle_inputs();
      if (c < 4) begin
        a = 16'h0400 + 16'(2 * c);
        if (kind[c]) begin d_req = 1'b1; d_addr = a; end
        else begin if_req = 1'b1; if_addr = a; end
      end
      mid();
      if (c < 4) begin
        total++;
        if (if_gnt !== !kind[c] || d_gnt !== kind[c]) begin
          bad++; $display("FAIL interleave_gnt c=%0d: got if=%b d=%b", c, if_gnt, d_gnt);
        end
      end
      if (c >= RD_LAT) begin
        a = 16'h0400 + 16'(2 * (c - RD_LAT));
        total++;
        if (if_rvalid !== !kind[c-RD_LAT] || d_rvalid !== kind[c-RD_LAT]) begin
          bad++; $display("FAIL interleave_owner c=%0d: got if=%b d=%b", c, if_rvalid, d_rvalid);
        end
        total++;
        if ((if_rdata | d_rdata) !== (a ^ 16'h5A3C) || (if_rdata | d_rdata) !== i_mem_rddata) begin
          bad++; $display("FAIL interleave_data c=%0d: got %h want %h", c, if_rdata | d_rdata, a ^ 16'h5A3C);
        end
      end else begin
        total++;
        if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
          bad++; $display("FAIL interleave_early c=%0d: got if=%b d=%b want 0 0", c, if_rvalid, d_rvalid);
        end
      end
    end
    $display("test_interleave: done");
  endtask

  task automatic test_reset_midflight();
    step();
    idle_inputs();
    d_req = 1'b1; d_addr = 16'h0500;
    mid();
    total++;
    if (d_gnt !== 1'b1) begin
      bad++; $display("FAIL midflight_gnt: got %b want 1", d_gnt);
    end
    step();
    idle_inputs();
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({if_gnt, d_gnt, d_rvalid, if_rvalid, o_mem_rd} !== 5'b0) begin
      bad++; $display("FAIL midflight_in_reset: got %b want 0", {if_gnt, d_gnt, d_rvalid, if_rvalid, o_mem_rd});
    end
    #1 rst_n = 1'b1;
    for (int k = 1; k <= RD_LAT + 2; k++) begin
      if (k > 1) step();
      mid();
      total++;
      if (d_rvalid !== 1'b0) begin
        bad++; $display("FAIL midflight_dropped k=%0d: got d_rvalid=%b want 0", k, d_rvalid);
      end
    end
    for (int k = 0; k <= RD_LAT; k++) begin
      step();
      idle_inputs();
      if (k == 0) begin if_req = 1'b1; if_addr = 16'h0000; end
      mid();
      if (k == 0) begin
        total++;
        if (if_gnt !== 1'b1 || dut.starve_cnt_reg !== 4'd0) begin
          bad++; $display("FAIL post_reset_fetch: got gnt=%b starve=%0d want 1 0", if_gnt, dut.starve_cnt_reg);
        end
      end
      if (k == RD_LAT) begin
        total++;
        if (if_rvalid !== 1'b1 || if_rdata !== 16'h5A3C) begin
          bad++; $display("FAIL post_reset_data: got v=%b data=%h want 1 5a3c", if_rvalid, if_rdata);
        end
      end
    end
    $display("test_reset_midflight: done");
  endtask

  task automatic test_idle();
    for (int k = 0; k < 5; k++) begin
      step();
      idle_inputs();
      mid();
      total++;
      if ({o_mem_rd, o_mem_wr, o_mem_addr, o_mem_wrdata, if_gnt, d_gnt, if_rvalid, d_rvalid} !== 38'h0) begin
        bad++; $display("FAIL idle k=%0d: got rd=%b wr=%b addr=%h wd=%h gnt=%b%b rv=%b%b", k,
                        o_mem_rd, o_mem_wr, o_mem_addr, o_mem_wrdata, if_gnt, d_gnt, if_rvalid, d_rvalid);
      end
    end
    $display("test_idle: done");
  endtask

  task automatic test_random();
    logic if_took = 1'b1;
    logic d_took  = 1'b1;
    for (int c = 0; c < 400 + RD_LAT + 2; c++) begin
      step();
      if (c >= 400) begin
        if (if_took) if_req = 1'b0;
        if (d_took)  d_req  = 1'b0;
      end else begin
        if (!if_req || if_took) begin
          if_req  = ($urandom_range(0, 3) != 0);
          if_addr = 16'h0700 + 16'($urandom_range(0, 7) * 2);
        end
        if (!d_req || d_took) begin
          d_req   = ($urandom_range(0, 2) != 0);
          d_we    = ($urandom_range(0, 2) == 0);
          d_addr  = 16'h0700 + 16'($urandom_range(0, 7) * 2);
          d_wdata = 16'($urandom);
        end
      end
      mid();
      total++;
      if ({if_gnt, d_gnt} !== {exp_if_gnt, exp_d_gnt}) begin
        bad++; $display("FAIL rand_gnt c=%0d: got %b%b want %b%b", c, if_gnt, d_gnt, exp_if_gnt, exp_d_gnt);
      end
      total++;
      if (o_mem_rd !== (exp_if_gnt || (exp_d_gnt && !d_we)) || o_mem_wr !== (exp_d_gnt && d_we) ||
          o_mem_addr !== (exp_if_gnt ? if_addr : (exp_d_gnt ? d_addr : 16'h0)) ||
          o_mem_wrdata !== ((exp_d_gnt && d_we) ? d_wdata : 16'h0)) begin
        bad++; $display("FAIL rand_mem c=%0d: got rd=%b wr=%b addr=%h wd=%h", c, o_mem_rd, o_mem_wr, o_mem_addr, o_mem_wrdata);
      end
      total++;
      if ({if_rvalid, d_rvalid} !== {exp_rv_if, exp_rv_d} ||
          if_rdata !== (exp_rv_if ? exp_rdata : 16'h0) || d_rdata !== (exp_rv_d ? exp_rdata : 16'h0)) begin
        bad++; $display("FAIL rand_resp c=%0d: got rv=%b%b if=%h d=%h want rv=%b%b data=%h",
                        c, if_rvalid, d_rvalid, if_rdata, d_rdata, exp_rv_if, exp_rv_d, exp_rdata);
      end
      if (exp_if_gnt) $display("txn c=%0d fetch rd addr=%h", c, if_addr);
      if (exp_d_gnt)  $display("txn c=%0d data %s addr=%h", c, d_we ? "wr" : "rd", d_addr);
      if_took = exp_if_gnt;
      d_took  = exp_d_gnt;
    end
    $display("test_random: done");
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fetch_only();
    test_contention();
    test_write();
    test_interleave();
    test_reset_midflight();
    test_idle();
    test_random();
    test_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
